// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode encodings, receiver FSM states and the
// 2-of-3 majority helper used for bit decisions.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a registered head word and
// registered full/empty flags.
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    rd_inc_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nx_s;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] head_nx_s;
    logic             full_r;
    logic             empty_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Accept/pop qualification, next occupancy and next head word.
    always_comb begin
        pop_ok_s   = pop & (count_r != {CW{1'b0}});
        push_ok_s  = push & ((count_r != DEPTH_C) | pop_ok_s);
        rd_inc_s   = rd_ptr_r + AW'(1);
        count_nx_s = count_r;
        head_nx_s  = head_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nx_s = count_r + CW'(1);
            2'b01:   count_nx_s = count_r - CW'(1);
            default: count_nx_s = count_r;
        endcase
        // A pop of the last word exposes either the simultaneous push or nothing.
        if (pop_ok_s) begin
            if (count_r == CW'(1)) begin
                head_nx_s = push_ok_s ? din : {WIDTH{1'b0}};
            end else begin
                head_nx_s = mem_r[rd_inc_s];
            end
        end else if (push_ok_s && (count_r == {CW{1'b0}})) begin
            head_nx_s = din;
        end else begin
            head_nx_s = head_r;
        end
    end

    // Storage array; contents are only ever read after being written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy, head register and flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            head_r   <= {WIDTH{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_inc_s;
            end
            count_r <= count_nx_s;
            head_r  <= head_nx_s;
            full_r  <= (count_nx_s == DEPTH_C);
            empty_r <= (count_nx_s == {CW{1'b0}});
        end
    end

    assign dout  = head_r;
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/uart_rx_fifo_cfg.sv
// Configurable UART receiver (5..9 data bits, optional parity, 1/2 stop bits) with
// majority-voted sampling and a FWFT receive FIFO carrying per-word error flags.
module uart_rx_fifo_cfg
    import uart_pkg::*;
#(
    parameter int         CLK_FRE    = 100,
    parameter int         BAUD_RATE  = 115200,
    parameter int         DATA_BITS  = 8,
    parameter logic [1:0] PARITY     = PAR_NONE,
    parameter int         STOP_BITS  = 1,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_data_valid,
    input  logic                 rx_data_ready,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int              CYCLE     = CLK_FRE * 1000000 / BAUD_RATE;
    localparam logic [15:0]     CYC_LAST  = 16'(CYCLE - 1);
    localparam logic [15:0]     HALF_LAST = 16'(CYCLE / 2 - 1);
    localparam logic [3:0]      BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic            STOP_LAST = (STOP_BITS == 2);
    localparam int              FW        = DATA_BITS + 2;

    logic                 sync1_r;
    logic                 rx_sync_r;
    logic [1:0]           hist_r;
    rx_state_t            state_r;
    rx_state_t            state_nx_s;
    logic [15:0]          cycle_cnt_r;
    logic [15:0]          cycle_cnt_nx_s;
    logic [3:0]           bit_cnt_r;
    logic [3:0]           bit_cnt_nx_s;
    logic                 stop_cnt_r;
    logic                 stop_cnt_nx_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_nx_s;
    logic                 frame_err_r;
    logic                 frame_err_nx_s;
    logic                 parity_err_r;
    logic                 parity_err_nx_s;
    logic                 busy_r;
    logic                 overrun_r;
    logic                 bit_s;
    logic                 fall_s;
    logic                 push_s;
    logic [FW-1:0]        push_word_s;
    logic [FW-1:0]        head_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;

    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
        return ((^d) ^ p) != (PARITY == PAR_ODD);
    endfunction

    // Two-flop synchroniser plus a two-deep history of the synchronised line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r   <= 1'b1;
            rx_sync_r <= 1'b1;
            hist_r    <= 2'b11;
        end else begin
            sync1_r   <= rx_pin;
            rx_sync_r <= sync1_r;
            hist_r    <= {hist_r[0], rx_sync_r};
        end
    end

    // Samples at cnt-2, cnt-1 and cnt are voted on the decision clock itself.
    assign bit_s  = maj3(hist_r[1], hist_r[0], rx_sync_r);
    assign fall_s = hist_r[0] & ~rx_sync_r;

    // Next-state, counter and datapath logic of the receive FSM.
    always_comb begin
        state_nx_s      = state_r;
        cycle_cnt_nx_s  = cycle_cnt_r + 16'd1;
        bit_cnt_nx_s    = bit_cnt_r;
        stop_cnt_nx_s   = stop_cnt_r;
        shift_nx_s      = shift_r;
        frame_err_nx_s  = frame_err_r;
        parity_err_nx_s = parity_err_r;
        push_s          = 1'b0;
        push_word_s     = {frame_err_r, parity_err_r, shift_r};
        case (state_r)
            RX_IDLE: begin
                cycle_cnt_nx_s  = 16'd0;
                bit_cnt_nx_s    = 4'd0;
                stop_cnt_nx_s   = 1'b0;
                frame_err_nx_s  = 1'b0;
                parity_err_nx_s = 1'b0;
                if (fall_s) begin
                    state_nx_s = RX_START;
                end else begin
                    state_nx_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (cycle_cnt_r == HALF_LAST) begin
                    cycle_cnt_nx_s = 16'd0;
                    state_nx_s     = bit_s ? RX_IDLE : RX_DATA;
                end else begin
                    state_nx_s = RX_START;
                end
            end
            RX_DATA: begin
                if (cycle_cnt_r == CYC_LAST) begin
                    cycle_cnt_nx_s = 16'd0;
                    shift_nx_s     = {bit_s, shift_r[DATA_BITS-1:1]};
                    if (bit_cnt_r == BIT_LAST) begin
                        bit_cnt_nx_s = 4'd0;
                        state_nx_s   = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                    end else begin
                        bit_cnt_nx_s = bit_cnt_r + 4'd1;
                        state_nx_s   = RX_DATA;
                    end
                end else begin
                    state_nx_s = RX_DATA;
                end
            end
            RX_PARITY: begin
                if (cycle_cnt_r == CYC_LAST) begin
                    cycle_cnt_nx_s  = 16'd0;
                    parity_err_nx_s = parity_bad(shift_r, bit_s);
                    state_nx_s      = RX_STOP;
                end else begin
                    state_nx_s = RX_PARITY;
                end
            end
            RX_STOP: begin
                if (cycle_cnt_r == CYC_LAST) begin
                    cycle_cnt_nx_s = 16'd0;
                    frame_err_nx_s = frame_err_r | ~bit_s;
                    if (stop_cnt_r == STOP_LAST) begin
                        // Leave mid stop bit so a back-to-back start edge is not missed.
                        push_s      = 1'b1;
                        push_word_s = {frame_err_r | ~bit_s, parity_err_r, shift_r};
                        state_nx_s  = RX_IDLE;
                    end else begin
                        stop_cnt_nx_s = 1'b1;
                        state_nx_s    = RX_STOP;
                    end
                end else begin
                    state_nx_s = RX_STOP;
                end
            end
            default: begin
                state_nx_s     = RX_IDLE;
                cycle_cnt_nx_s = 16'd0;
            end
        endcase
    end

    // FSM state, counters, shift register and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= RX_IDLE;
            cycle_cnt_r  <= 16'd0;
            bit_cnt_r    <= 4'd0;
            stop_cnt_r   <= 1'b0;
            shift_r      <= {DATA_BITS{1'b0}};
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            busy_r       <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            cycle_cnt_r  <= cycle_cnt_nx_s;
            bit_cnt_r    <= bit_cnt_nx_s;
            stop_cnt_r   <= stop_cnt_nx_s;
            shift_r      <= shift_nx_s;
            frame_err_r  <= frame_err_nx_s;
            parity_err_r <= parity_err_nx_s;
            busy_r       <= (state_nx_s != RX_IDLE);
            overrun_r    <= push_s & fifo_full_s & ~(rx_data_ready & ~fifo_empty_s);
        end
    end

    uart_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .din   (push_word_s),
        .pop   (rx_data_ready),
        .dout  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign rx_data       = head_s[DATA_BITS-1:0];
    assign rx_parity_err = head_s[DATA_BITS];
    assign rx_frame_err  = head_s[DATA_BITS+1];
    assign rx_data_valid = ~fifo_empty_s;
    assign rx_overrun    = overrun_r;
    assign rx_busy       = busy_r;

endmodule
